// File: rtl/sonic_pcs_pg_pkg.sv
// Shared constants for the PCS pattern-generator mode sequencer.
// Holds the mode codes, the register map and the FSM state encoding.
// No logic here apart from one small helper function.
package sonic_pcs_pg_pkg;

  // Mode codes carried on the PG mode stream
  localparam logic [1:0] PG_IDLE   = 2'd0;
  localparam logic [1:0] PG_PRBS31 = 2'd1;
  localparam logic [1:0] PG_FIXED  = 2'd2;
  localparam logic [1:0] PG_SQUARE = 2'd3;

  // Word addresses of the configuration registers
  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_STATUS = 1;
  localparam int ADDR_SLOT0  = 2;

  // CTRL bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_LOOP_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DWELL = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

  // A last_slot beyond the table is clamped to the final table entry
  function automatic logic [3:0] sat_last_slot(input logic [3:0] req, input int num_slots);
    if (int'(req) >= num_slots) begin
      return 4'(num_slots - 1);
    end
    return req;
  endfunction

endpackage

// File: rtl/sonic_pcs_pg_seq_regs.sv
// Avalon-MM register file: slot table, CTRL fields, sticky done/aborted status.
// Latency: write takes effect next cycle; read data valid 1 cycle after cfg_read.
// Backpressure: none (no waitrequest); table/last_slot writes dropped while busy.
// SONIC_PG_SEQ_LOOP_EN: when defined, CTRL b2 holds the loop flag; otherwise it reads 0.
module sonic_pcs_pg_seq_regs
  import sonic_pcs_pg_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int DWELL_W   = 16,
  parameter int ADDR_W    = 5,
  localparam int SIDX_W   = $clog2(NUM_SLOTS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  cfg_address,
  input  logic               cfg_write,
  input  logic [31:0]        cfg_writedata,
  input  logic               cfg_read,
  output logic [31:0]        cfg_readdata,
  input  logic               busy,
  input  logic [3:0]         cur_slot,
  input  logic               done_set,
  input  logic               aborted_set,
  input  logic [SIDX_W-1:0]  rd_idx,
  output logic [1:0]         rd_mode,
  output logic [DWELL_W-1:0] rd_dwell,
  output logic [3:0]         last_slot,
  output logic               loop,
  output logic               start_pulse,
  output logic               abort_pulse
);

  logic [1:0]         mode_q  [NUM_SLOTS];
  logic [1:0]         mode_d  [NUM_SLOTS];
  logic [DWELL_W-1:0] dwell_q [NUM_SLOTS];
  logic [DWELL_W-1:0] dwell_d [NUM_SLOTS];
  logic [3:0]         last_slot_q, last_slot_d;
  logic               loop_q, loop_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               ctrl_wr;
  logic               status_rd;
  logic               slot_hit;
  logic [SIDX_W-1:0]  cfg_idx;
  logic               unused_wdata;

  assign ctrl_wr     = cfg_write && (cfg_address == ADDR_W'(ADDR_CTRL));
  assign status_rd   = cfg_read && (cfg_address == ADDR_W'(ADDR_STATUS));
  assign slot_hit    = (int'(cfg_address) >= ADDR_SLOT0) &&
                       (int'(cfg_address) < ADDR_SLOT0 + NUM_SLOTS);
  assign cfg_idx     = SIDX_W'(cfg_address - ADDR_W'(ADDR_SLOT0));
  assign start_pulse = ctrl_wr && cfg_writedata[CTRL_START_BIT];
  assign abort_pulse = ctrl_wr && cfg_writedata[CTRL_ABORT_BIT];
  // Upper write-data bits carry no fields
  assign unused_wdata = ^cfg_writedata;

  assign rd_mode      = mode_q[rd_idx];
  assign rd_dwell     = dwell_q[rd_idx];
  assign last_slot    = last_slot_q;
  assign loop         = loop_q;
  assign cfg_readdata = rdata_q;

  // Slot table and CTRL fields; frozen while the schedule runs
  always_comb begin
    mode_d      = mode_q;
    dwell_d     = dwell_q;
    last_slot_d = last_slot_q;
    loop_d      = loop_q;
    if (cfg_write && slot_hit && !busy) begin
      mode_d[cfg_idx]  = cfg_writedata[1:0];
      dwell_d[cfg_idx] = cfg_writedata[DWELL_W+1:2];
    end
    if (ctrl_wr && !busy) begin
      last_slot_d = sat_last_slot(cfg_writedata[7:4], NUM_SLOTS);
`ifdef SONIC_PG_SEQ_LOOP_EN
      loop_d = cfg_writedata[CTRL_LOOP_BIT];
`else
      loop_d = 1'b0;
`endif
    end
  end

  // Sticky status: a new event in the same cycle as a STATUS read survives the clear
  always_comb begin
    done_d    = done_set    || (done_q    && !status_rd);
    aborted_d = aborted_set || (aborted_q && !status_rd);
  end

  // Registered read mux; unmapped or idle cycles return 0
  always_comb begin
    rdata_d = '0;
    if (cfg_read) begin
      if (cfg_address == ADDR_W'(ADDR_CTRL)) begin
        rdata_d[7:4]          = last_slot_q;
        rdata_d[CTRL_LOOP_BIT] = loop_q;
      end else if (cfg_address == ADDR_W'(ADDR_STATUS)) begin
        rdata_d[0]   = busy;
        rdata_d[1]   = done_q;
        rdata_d[7:4] = cur_slot;
        rdata_d[8]   = aborted_q;
      end else if (slot_hit) begin
        rdata_d[1:0]         = mode_q[cfg_idx];
        rdata_d[DWELL_W+1:2] = dwell_q[cfg_idx];
      end
    end
  end

  // Register state, cleared by async reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        mode_q[i]  <= '0;
        dwell_q[i] <= '0;
      end
      last_slot_q <= '0;
      loop_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      mode_q      <= mode_d;
      dwell_q     <= dwell_d;
      last_slot_q <= last_slot_d;
      loop_q      <= loop_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: rtl/sonic_pcs_pg_mode_sequencer.sv
// Steps the PG mode stream through the programmed (mode, dwell) schedule.
// Latency: first code offered 1 cycle after start; dwell d = d+1 cycles between handshakes.
// Backpressure: pg_data held while pg_ready=0; dwell timing starts only after acceptance.
// SONIC_PG_SEQ_LOOP_EN (in the register block) enables wrap-around after last_slot.
module sonic_pcs_pg_mode_sequencer #(
  parameter int NUM_SLOTS = 8,
  parameter int DWELL_W   = 16,
  parameter int ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cfg_address,
  input  logic              cfg_write,
  input  logic [31:0]       cfg_writedata,
  input  logic              cfg_read,
  output logic [31:0]       cfg_readdata,
  output logic              pg_valid,
  output logic [1:0]        pg_data,
  input  logic              pg_ready,
  output logic              seq_busy,
  output logic              seq_done_irq
);
  import sonic_pcs_pg_pkg::*;

  localparam int SIDX_W = $clog2(NUM_SLOTS);

  seq_state_e         state_q, state_d;
  seq_state_e         adv_state;
  logic [3:0]         slot_q, slot_d, adv_slot;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               abort_pend_q, abort_pend_d;
  logic               irq_q, irq_d;

  logic [1:0]         rd_mode;
  logic [DWELL_W-1:0] rd_dwell;
  logic [3:0]         last_slot;
  logic               loop;
  logic               start_pulse;
  logic               abort_pulse;
  logic               done_set;
  logic               aborted_set;
  logic               at_last;

  sonic_pcs_pg_seq_regs #(
    .NUM_SLOTS (NUM_SLOTS),
    .DWELL_W   (DWELL_W),
    .ADDR_W    (ADDR_W)
  ) u_regs (
    .clk           (clk),
    .reset_n       (reset_n),
    .cfg_address   (cfg_address),
    .cfg_write     (cfg_write),
    .cfg_writedata (cfg_writedata),
    .cfg_read      (cfg_read),
    .cfg_readdata  (cfg_readdata),
    .busy          (seq_busy),
    .cur_slot      (slot_q),
    .done_set      (done_set),
    .aborted_set   (aborted_set),
    .rd_idx        (slot_q[SIDX_W-1:0]),
    .rd_mode       (rd_mode),
    .rd_dwell      (rd_dwell),
    .last_slot     (last_slot),
    .loop          (loop),
    .start_pulse   (start_pulse),
    .abort_pulse   (abort_pulse)
  );

  // Outputs decode straight from the state flop so reset clears them asynchronously
  assign pg_valid     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign pg_data      = (state_q == ST_ISSUE) ? rd_mode : PG_IDLE;
  assign seq_busy     = (state_q != ST_IDLE);
  assign seq_done_irq = irq_q;
  assign done_set     = (state_q == ST_DRAIN) && pg_ready;
  assign aborted_set  = abort_pulse && (state_q != ST_IDLE);
  assign at_last      = (slot_q == last_slot);

  // Where the schedule goes once the current slot's dwell has elapsed
  always_comb begin
    adv_state = ST_ISSUE;
    adv_slot  = slot_q + 4'd1;
    if (at_last) begin
      if (loop) begin
        adv_slot = '0;
      end else begin
        adv_state = ST_DRAIN;
        adv_slot  = slot_q;
      end
    end
  end

  // Schedule FSM: issue, dwell, drain; abort deferred until an offered code is taken
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    cnt_d        = cnt_q;
    abort_pend_d = abort_pend_q;
    irq_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (start_pulse && !abort_pulse) begin
          state_d = ST_ISSUE;
          slot_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (pg_ready) begin
          abort_pend_d = 1'b0;
          if (abort_pulse || abort_pend_q) begin
            state_d = ST_DRAIN;
          end else if (rd_dwell != '0) begin
            state_d = ST_DWELL;
            cnt_d   = rd_dwell - DWELL_W'(1);
          end else begin
            state_d = adv_state;
            slot_d  = adv_slot;
          end
        end else if (abort_pulse) begin
          abort_pend_d = 1'b1;
        end
      end
      ST_DWELL: begin
        if (abort_pulse) begin
          state_d = ST_DRAIN;
        end else if (cnt_q == '0) begin
          state_d = adv_state;
          slot_d  = adv_slot;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      ST_DRAIN: begin
        if (pg_ready) begin
          state_d = ST_IDLE;
          irq_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and counter state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      cnt_q        <= '0;
      abort_pend_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      cnt_q        <= cnt_d;
      abort_pend_q <= abort_pend_d;
      irq_q        <= irq_d;
    end
  end

endmodule
